// File: rtl/apb_sram_slave_param.sv
// APB3 slave SRAM with programmable wait states and error response.
// Optional write protection of the upper half: APB_SRAM_WRITE_PROTECT_EN.
module apb_sram_slave_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  P_clk,
  input  logic                  P_rst_n,
  input  logic [ADDR_WIDTH-1:0] P_addr,
  input  logic                  P_selx,
  input  logic                  P_enable,
  input  logic                  P_write,
  input  logic [DATA_WIDTH-1:0] P_wdata,
`ifdef APB_SRAM_WRITE_PROTECT_EN
  input  logic                  P_wprot,
`endif
  output logic                  P_ready,
  output logic [DATA_WIDTH-1:0] P_rdata,
  output logic                  P_slverr
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int BW = $clog2(B);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH * B);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(B - 1);
  localparam logic [3:0]            WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   a_idx;
  logic            wr;
  logic            err;
  logic            a_ok;
  logic            a_err;
  logic            setup;
  logic            done;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign a_idx = P_addr[BW +: IW];
  assign a_ok  = ({1'b0, P_addr} < LIMIT) && ((P_addr & AMASK) == '0);
`ifdef APB_SRAM_WRITE_PROTECT_EN
  assign a_err = !a_ok || (P_write && P_wprot && a_idx[IW-1]);
`else
  assign a_err = !a_ok;
`endif
  assign setup = (state == IDLE) && P_selx && !P_enable;
  assign done  = (state == ACCESS) && P_ready && P_selx && P_enable;

  always_ff @(posedge P_clk) begin
    if (P_rst_n && done && wr && !err)
      mem[idx] <= P_wdata;
  end

  always_ff @(posedge P_clk) begin
    if (!P_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      P_ready  <= 1'b0;
      P_slverr <= 1'b0;
      P_rdata  <= '0;
      idx      <= '0;
      wr       <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            idx   <= a_idx;
            wr    <= P_write;
            err   <= a_err;
            cnt   <= '0;
            state <= ACCESS;
            if (!P_write)
              P_rdata <= a_ok ? mem[a_idx] : '0;
            // zero wait states: completion is offered on the first access cycle
            if (WS == 4'd0) begin
              P_ready  <= 1'b1;
              P_slverr <= a_err;
            end
          end
        end
        ACCESS: begin
          if (!P_selx) begin
            state    <= IDLE;
            cnt      <= '0;
            P_ready  <= 1'b0;
            P_slverr <= 1'b0;
          end else if (!P_ready) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == WS) begin
              P_ready  <= 1'b1;
              P_slverr <= err;
            end
          end else if (P_enable) begin
            state    <= IDLE;
            cnt      <= '0;
            P_ready  <= 1'b0;
            P_slverr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_sram_slave_param.md
Name: apb_sram_slave_param

Overview:
- Parametrised APB3 slave SRAM; successor to the fixed 32-entry APB memory.
- Slave-generated P_ready with programmable wait states, P_slverr for illegal addresses, byte-addressed word-aligned decode, configurable data width and depth.
- Sits on the APB peripheral bus behind the bridge as a scratch/config RAM.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 32, P_addr width in bits.
- DEPTH, 64, number of words; power of two, at least 2.
- WAIT_STATES, 0, access-phase cycles with P_ready low before completion; range 0..15.

Ports:
- P_clk  input  1  bus clock; all logic on the rising edge.
- P_rst_n  input  1  synchronous active-low reset.
- P_addr  input  ADDR_WIDTH  byte address.
- P_selx  input  1  slave select.
- P_enable  input  1  access-phase strobe.
- P_write  input  1  1 = write, 0 = read.
- P_wdata  input  DATA_WIDTH  write data.
- P_ready  output  1  transfer completion, registered.
- P_rdata  output  DATA_WIDTH  read data, registered.
- P_slverr  output  1  error response, valid only while P_ready = 1.

Behaviour:
- Reset (P_rst_n = 0 at a rising edge): state IDLE, wait counter 0, P_ready 0, P_slverr 0, P_rdata 0. Memory contents are not reset. Reset mid-transfer aborts the transfer with no memory write.
- Definitions:
  - B = DATA_WIDTH/8 (bytes per word).
  - Word index = P_addr[log2(B) +: log2(DEPTH)].
  - Address is illegal if P_addr >= DEPTH*B or P_addr[log2(B)-1:0] != 0.
- FSM state IDLE:
  - Setup phase is a cycle with P_selx = 1 and P_enable = 0.
  - On a setup-phase edge, latch word index, P_write and legality; go to ACCESS.
  - In the same edge, on a legal read, load P_rdata with mem[index]. On an illegal read, load 0.
  - P_enable = 1 while in IDLE is ignored (no setup seen).
- FSM state ACCESS:
  - Counter increments each edge while P_ready = 0.
  - P_ready is set at the edge where the counter reaches WAIT_STATES. With WAIT_STATES = 0, P_ready goes high on the same edge that enters ACCESS.
  - The completion edge is one where P_ready = 1, P_selx = 1 and P_enable = 1.
  - At the completion edge: on a legal write, mem[index] <= P_wdata. Then clear P_ready, P_slverr and the counter, and go to IDLE.
- P_slverr is driven with P_ready for illegal addresses. An illegal write leaves memory unchanged.
- P_rdata holds its value outside reads; it is never cleared after completion.
- Master drops P_selx in ACCESS before completion: abort to IDLE, no write, P_ready 0.
- Transfer timing:
  - Each transfer takes 2 + WAIT_STATES cycles, counted from the setup cycle to completion.
  - Back-to-back transfers need no idle cycle between them: a setup cycle directly after completion is recognised in IDLE.
- Read-after-write to the same index returns the new data.

Optional Feature:
- Macro: APB_SRAM_WRITE_PROTECT_EN.
- Defined:
  - Adds input port P_wprot (1 bit), sampled in the setup phase.
  - A write with P_wprot = 1 to the upper half of memory (index >= DEPTH/2) is not performed and completes with P_slverr = 1.
  - Reads are unaffected.
- Undefined: no P_wprot port; all legal writes are performed.

Test Plan:
- Reset release, defaults (WAIT_STATES = 0): write 0xDEADBEEF to 0x10, then read 0x10 -> each transfer has P_ready high in the cycle after setup; read returns P_rdata = 0xDEADBEEF, P_slverr = 0.
- WAIT_STATES = 3: write 0x12345678 to 0x04 -> P_ready low for 3 access cycles, high on the 4th; the following read returns 0x12345678.
- Illegal addresses: write to 0x100 (DEPTH = 64, B = 4) and to 0x02 -> P_slverr = 1 with P_ready; memory unchanged; read of 0x100 returns P_rdata = 0 with P_slverr = 1.
- Back-to-back: write 0xA5A5A5A5 to 0x08, then an immediate read of 0x08 with no idle cycle -> completions 2 cycles apart; read data 0xA5A5A5A5.
- Abort/reset: with WAIT_STATES = 2, drop P_selx in the 1st access cycle of a write of 0xFFFFFFFF to 0x0C; separately assert P_rst_n = 0 mid-write -> no write; a later read of 0x0C returns the prior value; after reset P_ready = 0 and P_rdata = 0.
- With APB_SRAM_WRITE_PROTECT_EN: write 0x1 to index 40 with P_wprot = 1 -> P_slverr = 1, memory unchanged. The same write with P_wprot = 0 succeeds.
